// File: rtl/if_tag_pkg.sv
// Shared tag encodings, frame state and tag selection for the IF row tagger.
package if_tag_pkg;

  localparam logic [1:0] TAG_FIRST  = 2'b10;
  localparam logic [1:0] TAG_LAST   = 2'b01;
  localparam logic [1:0] TAG_MID    = 2'b00;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  // Counters are zero-extended to this width before tag selection.
  localparam int TAG_CNT_W = 16;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  function automatic logic [1:0] tag_of(input logic [TAG_CNT_W-1:0] col,
                                        input logic [TAG_CNT_W-1:0] row_len);
    if (row_len == TAG_CNT_W'(1))                return TAG_SINGLE;
    if (col == '0)                               return TAG_FIRST;
    if (col == row_len - TAG_CNT_W'(1))          return TAG_LAST;
    return TAG_MID;
  endfunction

endpackage

// File: rtl/if_hold_reg.sv
// One-entry output register toward the IF FIFO; accepts a new word whenever it
// is empty or being drained in the same cycle.
module if_hold_reg #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         full_i,
  output logic         hold_v_o,
  output logic         can_load_o,
  output logic         wen_o,
  output logic [W-1:0] dout_o
);

  logic         hold_v_q, hold_v_d;
  logic [W-1:0] hold_data_q, hold_data_d;

  always_comb begin
    wen_o       = hold_v_q & ~full_i;
    can_load_o  = ~hold_v_q | ~full_i;
    hold_v_d    = load_i | (hold_v_q & ~wen_o);
    hold_data_d = load_i ? data_i : hold_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v_q    <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign hold_v_o = hold_v_q;
  assign dout_o   = hold_data_q;

endmodule

// File: rtl/if_row_tagger.sv
// Frames a raw sample stream into rows, prepends the 2-bit row tag and feeds
// the IF FIFO through a one-entry hold register.
module if_row_tagger
  import if_tag_pkg::*;
#(
  parameter int IF_SCRATCH_WIDTH = 16,
  parameter int ROW_LEN_W        = 8,
  parameter int ROW_CNT_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ROW_LEN_W-1:0]        row_len,
  input  logic [ROW_CNT_W-1:0]        row_cnt,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [IF_SCRATCH_WIDTH-1:0] s_data,
  output logic                        IF_wen,
  output logic [IF_SCRATCH_WIDTH+1:0] IF_din,
  input  logic                        IF_full,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err
);

  state_e                 state_q, state_d;
  logic [ROW_LEN_W-1:0]   len_q, len_d, col_q, col_d;
  logic [ROW_CNT_W-1:0]   cnt_q, cnt_d, row_q, row_d;
  logic                   done_q, done_d, cfg_err_q, cfg_err_d;
  logic                   hold_v, can_load, hs, row_end, frame_end, cfg_ok;
  logic [IF_SCRATCH_WIDTH+1:0] load_word;

  assign cfg_ok    = (row_len != '0) && (row_cnt != '0);
  assign hs        = s_valid & s_ready;
  assign row_end   = (col_q == len_q - ROW_LEN_W'(1));
  assign frame_end = row_end && (row_q == cnt_q - ROW_CNT_W'(1));
  assign load_word = {tag_of(TAG_CNT_W'(col_q), TAG_CNT_W'(len_q)), s_data};

  if_hold_reg #(.W(IF_SCRATCH_WIDTH+2)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load_i     (hs),
    .data_i     (load_word),
    .full_i     (IF_full),
    .hold_v_o   (hold_v),
    .can_load_o (can_load),
    .wen_o      (IF_wen),
    .dout_o     (IF_din)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d = STREAM;
            len_d   = row_len;
            cnt_d   = row_cnt;
            col_d   = '0;
            row_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (hs) begin
          if (row_end) begin
            col_d = '0;
            row_d = row_q + ROW_CNT_W'(1);
          end else begin
            col_d = col_q + ROW_LEN_W'(1);
          end
          if (frame_end) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Nothing loads in DRAIN, so a write here empties the hold register.
        if (!hold_v || IF_wen) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state_q == STREAM) & can_load;
    busy    = (state_q != IDLE);
    done    = done_q;
    cfg_err = cfg_err_q;
  end

endmodule

// File: tb/tb_if_row_tagger.sv
// Randomized bench for if_row_tagger against a frame-level occupancy model.
module tb_if_row_tagger;
  localparam int W = 16;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0, s_valid = 1'b0, IF_full = 1'b0;
  logic [7:0]    row_len = '0, row_cnt = '0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready, IF_wen, busy, done, cfg_err;
  logic [W+1:0]  IF_din;

  int errors = 0, checks = 0;
  int full_mode = 0;

  // Model state: samples still to accept, words accepted but unwritten.
  int  rem = 0, pend = 0, idx = 0, mlen = 1;
  bit  active = 0, done_pend = 0, cerr_pend = 0, blocked_prev = 0;
  logic [W+1:0] prev_din;
  logic [W+1:0] expq[$];
  logic [W+1:0] wlog[$];
  logic [W-1:0] samp[$];
  int  done_cnt = 0, cerr_cnt = 0;

  if_row_tagger #(.IF_SCRATCH_WIDTH(W), .ROW_LEN_W(8), .ROW_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len), .row_cnt(row_cnt),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .IF_wen(IF_wen), .IF_din(IF_din), .IF_full(IF_full),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_tag(input int k, input int len);
    int c;
    c = k % len;
    if (len == 1) return 2'b11;
    if (c == 0) return 2'b10;
    if (c == len - 1) return 2'b01;
    return 2'b00;
  endfunction

  always begin : full_gen
    int fc;
    fc = 0;
    forever begin
      @(posedge clk); #1;
      fc++;
      case (full_mode)
        1:       IF_full = ($urandom_range(0, 2) == 0);
        2:       IF_full = ((fc / 3) % 2) == 1;
        default: IF_full = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    bit e_rdy, e_wen, hs_n;
    if (!rst) begin
      rem = 0; pend = 0; active = 0; done_pend = 0; cerr_pend = 0; blocked_prev = 0;
      expq.delete();
    end else begin
      e_rdy = (rem > 0) && (pend == 0 || !IF_full);
      e_wen = (pend > 0) && !IF_full;
      chk("s_ready", s_ready, e_rdy);
      chk("IF_wen", IF_wen, e_wen);
      chk("busy", busy, active);
      chk("done", done, done_pend);
      chk("cfg_err", cfg_err, cerr_pend);
      if (blocked_prev) chk("din_stable", IF_din, prev_din);
      blocked_prev = (pend > 0) && IF_full;
      prev_din = IF_din;
      done_pend = 0;
      cerr_pend = 0;
      if (done) done_cnt++;
      if (cfg_err) cerr_cnt++;
      if (IF_wen) wlog.push_back(IF_din);
      if (e_wen) begin
        if (expq.size() > 0) chk("IF_din", IF_din, expq.pop_front());
        pend--;
      end
      hs_n = s_valid && e_rdy;
      if (hs_n) begin
        expq.push_back({exp_tag(idx, mlen), s_data});
        idx++; rem--; pend++;
      end
      if (active && e_wen && rem == 0 && pend == 0) begin
        done_pend = 1;
        active = 0;
      end else if (!active && start) begin
        if (row_len != 0 && row_cnt != 0) begin
          active = 1; rem = row_len * row_cnt; idx = 0; mlen = row_len;
        end else begin
          cerr_pend = 1;
        end
      end
    end
  end

  task automatic do_start(input int len, input int cnt);
    row_len = 8'(len); row_cnt = 8'(cnt); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; row_len = 8'($urandom); row_cnt = 8'($urandom);
  endtask

  task automatic fill_random(input int n);
    samp.delete();
    for (int i = 0; i < n; i++) samp.push_back(W'($urandom));
  endtask

  task automatic clear_log();
    wlog.delete(); done_cnt = 0; cerr_cnt = 0;
  endtask

  task automatic send(input int n, input int vprob, input int rst_after, input bit mid_start);
    int k, guard;
    bit hs, ms_sent;
    k = 0; guard = 0; ms_sent = 0;
    while (k < n && guard < 2000) begin
      if (rst_after >= 0 && k == rst_after) begin
        rst = 1'b0; s_valid = 1'b0; #1;
        chk("rst_wen", IF_wen, 0);
        chk("rst_din", IF_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        return;
      end
      s_valid = ($urandom_range(0, 99) < vprob);
      s_data  = samp[k];
      if (mid_start && k == 3 && !ms_sent) begin
        start = 1'b1; row_len = 8'd2; row_cnt = 8'd2; ms_sent = 1;
      end
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) k++;
      guard++;
    end
    s_valid = 1'b0;
    if (guard >= 2000) chk("send_timeout", k, n);
  endtask

  task automatic wait_done();
    int g, d0;
    g = 0; d0 = done_cnt;
    while (done_cnt == d0 && g < 300) begin
      @(posedge clk); g++;
    end
    #1;
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int t1[10] = '{88, 146, 78, -129, -123, -30, 68, -61, 28, -137};
    logic [1:0] lit_tags[4] = '{2'b10, 2'b00, 2'b00, 2'b01};
    int len, cnt;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_wen", IF_wen, 0);
    chk("reset_din", IF_din, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", s_ready, 0);
    chk("reset_done", done, 0);
    chk("reset_cfg_err", cfg_err, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Row of 10, single frame
    samp.delete();
    for (int i = 0; i < 10; i++) samp.push_back(W'(t1[i]));
    clear_log(); full_mode = 0;
    do_start(10, 1); send(10, 100, -1, 0); wait_done();
    chk("t1_writes", wlog.size(), 10);
    if (wlog.size() == 10) begin
      chk("t1_first", wlog[0], 18'h20058);
      chk("t1_second", wlog[1], 18'h00092);
      chk("t1_ninth", wlog[8], 18'h0001C);
      chk("t1_last", wlog[9], 18'h1FF77);
    end
    chk("t1_done", done_cnt, 1);

    // Multiple rows with periodic backpressure
    fill_random(12); clear_log(); full_mode = 2;
    do_start(4, 3); send(12, 80, -1, 0); wait_done();
    chk("t2_writes", wlog.size(), 12);
    if (wlog.size() == 12)
      for (int i = 0; i < 12; i++) chk("t2_tag", wlog[i][W+1:W], lit_tags[i % 4]);
    chk("t2_done", done_cnt, 1);

    // Single-sample rows
    fill_random(4); clear_log(); full_mode = 1;
    do_start(1, 4); send(4, 70, -1, 0); wait_done();
    chk("t3_writes", wlog.size(), 4);
    foreach (wlog[i]) chk("t3_tag", wlog[i][W+1:W], 2'b11);

    // Bad configurations
    clear_log(); full_mode = 0;
    do_start(0, 5); repeat (3) @(posedge clk);
    #1;
    chk("t4_cfg_err", cerr_cnt, 1);
    do_start(7, 0); repeat (3) @(posedge clk);
    #1;
    chk("t4_cfg_err2", cerr_cnt, 2);
    chk("t4_writes", wlog.size(), 0);

    // Reset mid-frame, then a clean frame
    fill_random(10); clear_log(); full_mode = 0;
    do_start(10, 1); send(10, 100, 5, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt, 0);
    fill_random(6); clear_log(); full_mode = 1;
    do_start(3, 2); send(6, 90, -1, 0); wait_done();
    chk("t5_writes", wlog.size(), 6);
    if (wlog.size() > 0) chk("t5_first_tag", wlog[0][W+1:W], 2'b10);

    // Start while busy is ignored
    fill_random(10); clear_log(); full_mode = 1;
    do_start(5, 2); send(10, 85, -1, 1); wait_done();
    chk("t6_writes", wlog.size(), 10);
    if (wlog.size() == 10) begin
      chk("t6_tag1", wlog[1][W+1:W], 2'b00);
      chk("t6_tag4", wlog[4][W+1:W], 2'b01);
      chk("t6_tag5", wlog[5][W+1:W], 2'b10);
    end
    chk("t6_done", done_cnt, 1);

    // Random frames
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 6); cnt = $urandom_range(1, 4);
      fill_random(len * cnt); clear_log(); full_mode = $urandom_range(0, 2);
      do_start(len, cnt); send(len * cnt, $urandom_range(40, 100), -1, 0); wait_done();
      chk("rand_writes", wlog.size(), len * cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
